// File: rtl/usb_std_pkg.sv
// usb_std_pkg: request/descriptor codes, ROM layout and FSM types shared by the USB standard-request handler
package usb_std_pkg;
  localparam logic [7:0] RT_IN = 8'h80;
  localparam logic [7:0] RT_OUT = 8'h00;
  localparam logic [7:0] REQ_GET_STATUS = 8'h00;
  localparam logic [7:0] REQ_SET_ADDRESS = 8'h05;
  localparam logic [7:0] REQ_GET_DESCRIPTOR = 8'h06;
  localparam logic [7:0] REQ_GET_CONFIGURATION = 8'h08;
  localparam logic [7:0] REQ_SET_CONFIGURATION = 8'h09;
  localparam logic [7:0] DT_DEVICE = 8'h01;
  localparam logic [7:0] DT_CONFIG = 8'h02;
  localparam logic [7:0] DT_STRING = 8'h03;
  localparam logic [5:0] DEV_BASE = 6'd0;
  localparam logic [5:0] CFG_BASE = 6'd18;
  localparam logic [5:0] STS_BASE = 6'd36;
  localparam logic [5:0] LANG_BASE = 6'd38;
  localparam logic [5:0] PROD_BASE = 6'd42;
  localparam logic [5:0] DEV_LEN = 6'd18;
  localparam logic [5:0] CFG_LEN = 6'd18;
  localparam logic [5:0] STS_LEN = 6'd2;
  localparam logic [5:0] LANG_LEN = 6'd4;
  localparam logic [5:0] PROD_LEN = 6'd8;
  typedef enum logic [1:0] {ST_IDLE, ST_DECODE, ST_SEND, ST_WAIT} state_t;
  typedef enum logic [1:0] {ACT_STALL, ACT_SEND, ACT_ADDR, ACT_CONF} act_t;
endpackage

// File: rtl/usb_desc_rom.sv
// usb_desc_rom: combinational descriptor store (device, configuration, status, optional strings when USB_STD_REQ_STRING_EN)
// Ports: i_addr byte address, o_data byte at that address (0 beyond the end).
module usb_desc_rom (
  input  logic [5:0] i_addr,
  output logic [7:0] o_data
);
`ifdef USB_STD_REQ_STRING_EN
  localparam logic [5:0] N = 6'd50;
  localparam logic [7:0] ROM [0:49] = '{
    8'h12, 8'h01, 8'h10, 8'h01, 8'h00, 8'h00, 8'h00, 8'h40, 8'h34, 8'h12, 8'h78, 8'h56, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01,
    8'h09, 8'h02, 8'h12, 8'h00, 8'h01, 8'h01, 8'h00, 8'hC0, 8'h32, 8'h09, 8'h04, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00,
    8'h01, 8'h00,
    8'h04, 8'h03, 8'h09, 8'h04,
    8'h08, 8'h03, 8'h55, 8'h00, 8'h53, 8'h00, 8'h42, 8'h00};
`else
  localparam logic [5:0] N = 6'd38;
  localparam logic [7:0] ROM [0:37] = '{
    8'h12, 8'h01, 8'h10, 8'h01, 8'h00, 8'h00, 8'h00, 8'h40, 8'h34, 8'h12, 8'h78, 8'h56, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01,
    8'h09, 8'h02, 8'h12, 8'h00, 8'h01, 8'h01, 8'h00, 8'hC0, 8'h32, 8'h09, 8'h04, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00,
    8'h01, 8'h00};
`endif
  assign o_data = (i_addr < N) ? ROM[i_addr] : 8'h00;
endmodule

// File: rtl/usb_std_request.sv
// usb_std_request: USB chapter-9 standard request handler for endpoint 0 (string descriptors with USB_STD_REQ_STRING_EN)
// Ports: ctl_* latched SETUP fields + ctl_done status-stage pulse; xfer_tx_* IN data stream;
// xfer_rx_* OUT stream (always accepted, discarded); device_address, configured, req_stall pulse.
module usb_std_request
  import usb_std_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ctl_start,
  input  logic [3:0]  ctl_endpoint,
  input  logic [7:0]  ctl_request_type,
  input  logic [7:0]  ctl_request,
  input  logic [15:0] ctl_value,
  input  logic [15:0] ctl_index,
  input  logic [15:0] ctl_length,
  input  logic        ctl_done,
  output logic [7:0]  xfer_tx_tdata,
  output logic        xfer_tx_tlast,
  output logic        xfer_tx_tvalid,
  input  logic        xfer_tx_tready,
  input  logic [7:0]  xfer_rx_tdata,
  input  logic        xfer_rx_tlast,
  input  logic        xfer_rx_error,
  input  logic        xfer_rx_tvalid,
  output logic        xfer_rx_tready,
  output logic [6:0]  device_address,
  output logic        configured,
  output logic        req_stall
);
  state_t      r_state;
  logic [3:0]  r_ep;
  logic [7:0]  r_type;
  logic [7:0]  r_req;
  logic [15:0] r_value;
  logic [15:0] r_length;
  logic [5:0]  r_base;
  logic [5:0]  r_idx;
  logic [5:0]  r_count;
  logic        r_cfg;
  logic [7:0]  r_config;
  logic [6:0]  r_pending;
  logic [6:0]  r_addr;
  logic        r_configured;
  logic        r_stall;
  act_t        w_act;
  logic [5:0]  w_base;
  logic [5:0]  w_len;
  logic        w_cfg;
  logic        w_fixed;
  logic [5:0]  w_cnt;
  logic [7:0]  w_rom;
  logic        w_unused;
  usb_desc_rom u_rom (.i_addr(r_base + r_idx), .o_data(w_rom));
  always_comb begin
    w_act = ACT_STALL;
    w_base = 6'd0;
    w_len = 6'd0;
    w_cfg = 1'b0;
    w_fixed = 1'b0;
    if (r_ep == 4'd0 && r_type == RT_IN && r_req == REQ_GET_DESCRIPTOR) begin
      if (r_value[15:8] == DT_DEVICE) begin
        w_act = ACT_SEND;
        w_base = DEV_BASE;
        w_len = DEV_LEN;
      end else if (r_value[15:8] == DT_CONFIG) begin
        w_act = ACT_SEND;
        w_base = CFG_BASE;
        w_len = CFG_LEN;
      end
`ifdef USB_STD_REQ_STRING_EN
      else if (r_value[15:8] == DT_STRING && r_value[7:0] == 8'd0) begin
        w_act = ACT_SEND;
        w_base = LANG_BASE;
        w_len = LANG_LEN;
      end else if (r_value[15:8] == DT_STRING && r_value[7:0] == 8'd1) begin
        w_act = ACT_SEND;
        w_base = PROD_BASE;
        w_len = PROD_LEN;
      end
`endif
    end else if (r_ep == 4'd0 && r_type == RT_IN && r_req == REQ_GET_CONFIGURATION) begin
      w_act = ACT_SEND;
      w_len = 6'd1;
      w_cfg = 1'b1;
      w_fixed = 1'b1;
    end else if (r_ep == 4'd0 && r_type == RT_IN && r_req == REQ_GET_STATUS) begin
      w_act = ACT_SEND;
      w_base = STS_BASE;
      w_len = STS_LEN;
      w_fixed = 1'b1;
    end else if (r_ep == 4'd0 && r_type == RT_OUT && r_req == REQ_SET_ADDRESS) begin
      w_act = ACT_ADDR;
    end else if (r_ep == 4'd0 && r_type == RT_OUT && r_req == REQ_SET_CONFIGURATION) begin
      w_act = ACT_CONF;
    end
  end
  // Descriptors are truncated to wLength; GET_STATUS/GET_CONFIGURATION always return their fixed size.
  assign w_cnt = (!w_fixed && r_length < {10'd0, w_len}) ? r_length[5:0] : w_len;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ep <= 4'd0;
      r_type <= 8'd0;
      r_req <= 8'd0;
      r_value <= 16'd0;
      r_length <= 16'd0;
      r_base <= 6'd0;
      r_idx <= 6'd0;
      r_count <= 6'd0;
      r_cfg <= 1'b0;
      r_config <= 8'd0;
      r_pending <= 7'd0;
      r_addr <= 7'd0;
      r_configured <= 1'b0;
      r_stall <= 1'b0;
    end else begin
      r_stall <= 1'b0;
      if (ctl_start) begin
        r_state <= ST_DECODE;
        r_ep <= ctl_endpoint;
        r_type <= ctl_request_type;
        r_req <= ctl_request;
        r_value <= ctl_value;
        r_length <= ctl_length;
        r_idx <= 6'd0;
      end else if (r_state == ST_DECODE) begin
        r_state <= ST_IDLE;
        if (w_act == ACT_SEND) begin
          r_state <= (w_cnt == 6'd0) ? ST_IDLE : ST_SEND;
          r_base <= w_base;
          r_count <= w_cnt;
          r_cfg <= w_cfg;
        end else if (w_act == ACT_ADDR) begin
          r_state <= ST_WAIT;
          r_pending <= r_value[6:0];
        end else if (w_act == ACT_CONF) begin
          r_config <= r_value[7:0];
          r_configured <= |r_value[7:0];
        end else begin
          r_stall <= 1'b1;
        end
      end else if (r_state == ST_SEND && xfer_tx_tready) begin
        r_idx <= xfer_tx_tlast ? 6'd0 : r_idx + 6'd1;
        r_state <= xfer_tx_tlast ? ST_IDLE : ST_SEND;
      end else if (r_state == ST_WAIT && ctl_done) begin
        r_addr <= r_pending;
        r_state <= ST_IDLE;
      end
    end
  end
  assign xfer_tx_tvalid = r_state == ST_SEND;
  assign xfer_tx_tlast = (r_state == ST_SEND) && (r_idx == r_count - 6'd1);
  assign xfer_tx_tdata = r_cfg ? r_config : w_rom;
  assign xfer_rx_tready = 1'b1;
  assign device_address = r_addr;
  assign configured = r_configured;
  assign req_stall = r_stall;
  assign w_unused = &{1'b0, ctl_index, xfer_rx_tdata, xfer_rx_tlast, xfer_rx_error, xfer_rx_tvalid};
endmodule

// File: doc/usb_std_request.md
USB_STD_REQUEST -- requirements
Module: usb_std_request

Interface
REQ-001 SHALL have port: clk  input  1  single clock for all logic.
REQ-002 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port: ctl_start  input  1  one-cycle pulse; the ctl_* setup fields are valid.
REQ-004 SHALL have port: ctl_endpoint  input  4  endpoint of the SETUP.
REQ-005 SHALL have port: ctl_request_type  input  8  bmRequestType.
REQ-006 SHALL have port: ctl_request  input  8  bRequest.
REQ-007 SHALL have port: ctl_value  input  16  wValue.
REQ-008 SHALL have port: ctl_index  input  16  wIndex.
REQ-009 SHALL have port: ctl_length  input  16  wLength.
REQ-010 SHALL have port: ctl_done  input  1  one-cycle pulse when the status stage completes.
REQ-011 SHALL have port: xfer_tx_tdata  output  8  IN data-stage byte.
REQ-012 SHALL have port: xfer_tx_tlast  output  1  last data-stage byte.
REQ-013 SHALL have port: xfer_tx_tvalid  output  1  byte valid.
REQ-014 SHALL have port: xfer_tx_tready  input  1  consumer accepts the byte.
REQ-015 SHALL have ports: xfer_rx_tdata/tlast/error/tvalid  input  8/1/1/1  OUT data stage; and xfer_rx_tready  output  1.
REQ-016 SHALL have port: device_address  output  7  current USB address.
REQ-017 SHALL have port: configured  output  1  SET_CONFIGURATION value is nonzero.
REQ-018 SHALL have port: req_stall  output  1  one-cycle pulse when a request is unsupported.

Function
REQ-019 SHALL run a state machine: IDLE -> DECODE (the cycle after ctl_start) -> SEND or WAIT_DONE or IDLE.
REQ-020 SHALL accept ctl_start in any state, abort any SEND in progress, and restart at DECODE.
REQ-021 SHALL, for GET_DESCRIPTOR (0x80/0x06): select the descriptor by ctl_value[15:8] (1=device, 2=configuration), set count = min(ctl_length, descriptor length), and enter SEND when count > 0 or IDLE when count = 0.
REQ-022 SHALL, in SEND: hold xfer_tx_tvalid=1, take xfer_tx_tdata from ROM[base+idx], increment idx on tvalid&tready, assert tlast when idx = count-1, and go to IDLE after the tlast handshake.
REQ-023 SHALL hold tdata/tlast stable while tvalid=1 and tready=0.
REQ-024 SHALL, for GET_CONFIGURATION (0x80/0x08), send 1 byte equal to the config value; for GET_STATUS (0x80/0x00), send 2 bytes: 0x01, 0x00 (self-powered).
REQ-025 SHALL, for SET_ADDRESS (0x00/0x05), latch ctl_value[6:0] as pending and go to WAIT_DONE; device_address SHALL update the cycle after ctl_done, never earlier.
REQ-026 SHALL, for SET_CONFIGURATION (0x00/0x09), latch ctl_value[7:0] into the config register immediately, drive configured = (value != 0), and return to IDLE.
REQ-027 SHALL, for any other request, unknown descriptor type, or ctl_endpoint != 0, pulse req_stall in DECODE and return to IDLE without sending.
REQ-028 SHALL drive xfer_rx_tready=1 permanently and discard all OUT data.
REQ-029 SHALL keep xfer_tx_tvalid=0 outside SEND.

Reset
REQ-030 SHALL, on rst asynchronously: state=IDLE, idx=0, device_address=0, pending address=0, config=0, configured=0, xfer_tx_tvalid=0, xfer_tx_tlast=0, req_stall=0.
REQ-031 SHALL, on rst asserted mid-SEND, deassert tvalid immediately and not resume the transfer.

Configuration
REQ-032 SHALL, with USB_STD_REQ_STRING_EN defined, serve descriptor type 3: index 0 = language ID (4 bytes: 04 03 09 04), index 1 = product string; other indices SHALL stall.
REQ-033 SHALL, without USB_STD_REQ_STRING_EN, stall all type-3 requests and exclude the string ROM.

Structure
REQ-034 SHALL place request codes, descriptor type codes, ROM base offsets and descriptor lengths (device 18, configuration 18) in the shared package usb_std_pkg.
REQ-035 SHALL place the descriptor storage in one sub-module, usb_desc_rom (combinational address-in/byte-out).

Verification
REQ-036 SHALL verify: GET_DESCRIPTOR device, wLength=64 -> 18 bytes 12 01 10 01 ..., tlast on byte 18.
REQ-037 SHALL verify: GET_DESCRIPTOR configuration, wLength=9 -> 9 bytes 09 02 12 00 01 01 00 C0 32, tlast on byte 9.
REQ-038 SHALL verify: SET_ADDRESS 0x2A -> device_address stays 0 until ctl_done, then reads 0x2A the next cycle.
REQ-039 SHALL verify: tready toggled 1/0 every cycle during a device descriptor read -> every byte is delivered exactly once, in order, with data stable during stalls.
REQ-040 SHALL verify: bRequest 0x0C, or GET_DESCRIPTOR type 6 -> single req_stall pulse and no tvalid.
REQ-041 SHALL verify: a new ctl_start issued on byte 5 of a SEND -> the old stream is dropped and the new response starts at byte 0.
